// File: rtl/parity_serial_unit.sv
// Serial parity generator/checker for UART-style frames (none/even/odd/mark/space).
// Optional saturating error-frame counter on port err_count when PARITY_ERR_COUNT_EN is defined.
module parity_serial_unit #(
    parameter int MAX_BITS = 8,
    parameter int NB_W     = $clog2(MAX_BITS + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [2:0]      mode,
    input  logic [NB_W-1:0] nbits,
    input  logic            din,
    input  logic            din_valid,
    output logic            busy,
    output logic            parity_out,
    output logic            parity_ready,
    output logic [NB_W-1:0] bit_count,
    output logic            done,
    output logic            parity_err
`ifdef PARITY_ERR_COUNT_EN
    ,
    output logic [15:0]     err_count
`endif
);

    localparam logic [2:0] M_NONE  = 3'd0;
    localparam logic [2:0] M_EVEN  = 3'd1;
    localparam logic [2:0] M_ODD   = 3'd2;
    localparam logic [2:0] M_MARK  = 3'd3;
    localparam logic [2:0] M_SPACE = 3'd4;

    localparam logic [NB_W-1:0] MAX_NB = NB_W'(MAX_BITS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    state_t          state;
    logic [2:0]      mode_q;
    logic [NB_W-1:0] nb_q;
    logic            acc;
    logic            acc_x;
    logic [NB_W-1:0] bc_inc;

    function automatic logic [2:0] norm_mode(input logic [2:0] m);
        return (m > M_SPACE) ? M_NONE : m;
    endfunction

    function automatic logic [NB_W-1:0] clamp_nbits(input logic [NB_W-1:0] n);
        return ((n == '0) || (n > MAX_NB)) ? MAX_NB : n;
    endfunction

    function automatic logic parity_of(input logic [2:0] m, input logic a);
        case (m)
            M_EVEN, M_ODD: return a;
            M_MARK:        return 1'b1;
            default:       return 1'b0;
        endcase
    endfunction

`ifdef PARITY_ERR_COUNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction
`endif

    assign acc_x  = acc ^ din;
    assign bc_inc = bit_count + NB_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            mode_q       <= M_NONE;
            nb_q         <= MAX_NB;
            acc          <= 1'b0;
            busy         <= 1'b0;
            parity_out   <= 1'b0;
            parity_ready <= 1'b0;
            bit_count    <= '0;
            done         <= 1'b0;
            parity_err   <= 1'b0;
`ifdef PARITY_ERR_COUNT_EN
            err_count    <= 16'd0;
`endif
        end else begin
            done <= 1'b0;
            if (abort) begin
                state        <= S_IDLE;
                busy         <= 1'b0;
                parity_ready <= 1'b0;
            end else if (start) begin
                // Odd parity is even parity seeded with 1, so one XOR chain serves both.
                state        <= S_ACCUM;
                mode_q       <= norm_mode(mode);
                nb_q         <= clamp_nbits(nbits);
                acc          <= (norm_mode(mode) == M_ODD);
                parity_out   <= parity_of(norm_mode(mode), norm_mode(mode) == M_ODD);
                busy         <= 1'b1;
                parity_ready <= 1'b0;
                bit_count    <= '0;
                parity_err   <= 1'b0;
            end else if (din_valid) begin
                case (state)
                    S_ACCUM: begin
                        acc        <= acc_x;
                        bit_count  <= bc_inc;
                        parity_out <= parity_of(mode_q, acc_x);
                        if (bc_inc == nb_q) begin
                            if (mode_q == M_NONE) begin
                                state      <= S_IDLE;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                parity_err <= 1'b0;
                            end else begin
                                state        <= S_PARITY;
                                parity_ready <= 1'b1;
                            end
                        end
                    end
                    S_PARITY: begin
                        state        <= S_IDLE;
                        busy         <= 1'b0;
                        parity_ready <= 1'b0;
                        done         <= 1'b1;
                        parity_err   <= (din != parity_out);
`ifdef PARITY_ERR_COUNT_EN
                        if (din != parity_out)
                            err_count <= sat_inc16(err_count);
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parity_serial_unit.sv
// Scoreboard bench for parity_serial_unit: expected parity_err per frame is queued
// when the closing bit is driven and compared when done pulses.
module tb_parity_serial_unit;

    localparam int MAX_BITS = 8;
    localparam int NB_W     = $clog2(MAX_BITS + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [2:0]      mode = 3'd0;
    logic [NB_W-1:0] nbits = '0;
    logic            din = 1'b0;
    logic            din_valid = 1'b0;
    logic            busy;
    logic            parity_out;
    logic            parity_ready;
    logic [NB_W-1:0] bit_count;
    logic            done;
    logic            parity_err;
`ifdef PARITY_ERR_COUNT_EN
    logic [15:0]     err_count;
    int              model_cnt = 0;
`endif

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    parity_serial_unit #(.MAX_BITS(MAX_BITS), .NB_W(NB_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .nbits(nbits), .din(din), .din_valid(din_valid), .busy(busy),
        .parity_out(parity_out), .parity_ready(parity_ready), .bit_count(bit_count),
        .done(done), .parity_err(parity_err)
`ifdef PARITY_ERR_COUNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [2:0] m, input logic [NB_W-1:0] n);
        start = 1'b1; mode = m; nbits = n;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_count", 32'(bit_count), 0);
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            din = v[i]; din_valid = 1'b1;
            tick();
            din_valid = 1'b0;
        end
    endtask

    task automatic send_parity(input logic b, input logic exp_err);
        exp_q.push_back(exp_err);
        din = b; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        chk("slot_done", 32'(done), 1);
        chk("slot_busy", 32'(busy), 0);
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 0);
            end else begin
                logic e;
                e = exp_q.pop_front();
                chk("parity_err", 32'(parity_err), 32'(e));
`ifdef PARITY_ERR_COUNT_EN
                if (e && model_cnt < 65535) model_cnt++;
                chk("err_count", 32'(err_count), model_cnt);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pout", 32'(parity_out), 0);
        chk("rst_pready", 32'(parity_ready), 0);
        chk("rst_count", 32'(bit_count), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_perr", 32'(parity_err), 0);
        @(posedge clk); #3 reset = 1'b0;
        tick();

        // even, 0x5A -> parity 0, slot 0 correct
        start_frame(3'd1, NB_W'(8));
        send_bits(16'h5A, 8);
        chk("even_pready", 32'(parity_ready), 1);
        chk("even_pout", 32'(parity_out), 0);
        chk("even_count", 32'(bit_count), 8);
        send_parity(1'b0, 1'b0);

        // odd, 0x5A -> parity 1, slot 0 wrong
        start_frame(3'd2, NB_W'(8));
        chk("odd_seed", 32'(parity_out), 1);
        send_bits(16'h5A, 8);
        chk("odd_pout", 32'(parity_out), 1);
        send_parity(1'b0, 1'b1);

        // none, 7 bits of 0x41
        start_frame(3'd0, NB_W'(7));
        exp_q.push_back(1'b0);
        send_bits(16'h41, 7);
        chk("none_done", 32'(done), 1);
        chk("none_pready", 32'(parity_ready), 0);
        chk("none_count", 32'(bit_count), 7);
        chk("none_busy", 32'(busy), 0);

        // mark then space, 5 bits of zero, slot 1
        start_frame(3'd3, NB_W'(5));
        send_bits(16'h00, 5);
        chk("mark_pout", 32'(parity_out), 1);
        send_parity(1'b1, 1'b0);
        start_frame(3'd4, NB_W'(5));
        send_bits(16'h00, 5);
        chk("space_pout", 32'(parity_out), 0);
        send_parity(1'b1, 1'b1);

        // abort in IDLE holds parity_err; din_valid in IDLE ignored
        abort = 1'b1; tick(); abort = 1'b0;
        chk("idle_abort_perr", 32'(parity_err), 1);
        din = 1'b1; din_valid = 1'b1;
        tick(); tick(); tick();
        din_valid = 1'b0;
        chk("idle_dv_count", 32'(bit_count), 5);
        chk("idle_dv_busy", 32'(busy), 0);

        // reserved mode 6 behaves as none
        start_frame(3'd6, NB_W'(3));
        exp_q.push_back(1'b0);
        send_bits(16'h5, 3);
        chk("rsv_done", 32'(done), 1);
        chk("rsv_pready", 32'(parity_ready), 0);

        // mode/nbits changed mid-frame are ignored
        start_frame(3'd1, NB_W'(4));
        mode = 3'd2; nbits = NB_W'(2);
        send_bits(16'h7, 4);
        chk("latch_count", 32'(bit_count), 4);
        chk("latch_pready", 32'(parity_ready), 1);
        chk("latch_pout", 32'(parity_out), 1);
        send_parity(1'b1, 1'b0);

        // restart with coincident din_valid, then abort
        start_frame(3'd1, NB_W'(8));
        send_bits(16'h5, 3);
        start = 1'b1; mode = 3'd1; nbits = NB_W'(8); din = 1'b1; din_valid = 1'b1;
        tick();
        start = 1'b0; din_valid = 1'b0;
        chk("restart_count", 32'(bit_count), 0);
        chk("restart_busy", 32'(busy), 1);
        chk("restart_pout", 32'(parity_out), 0);
        send_bits(16'h3, 2);
        chk("restart_acc", 32'(bit_count), 2);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_perr", 32'(parity_err), 0);
        tick();
        chk("abort_done2", 32'(done), 0);

        // start in the done cycle
        start_frame(3'd1, NB_W'(2));
        send_bits(16'h3, 2);
        chk("dstart_pout", 32'(parity_out), 0);
        send_parity(1'b1, 1'b1);
        start = 1'b1; mode = 3'd2; nbits = '0;
        tick();
        start = 1'b0;
        chk("dstart_perr", 32'(parity_err), 0);
        chk("dstart_busy", 32'(busy), 1);
        chk("dstart_done", 32'(done), 0);
        chk("dstart_seed", 32'(parity_out), 1);
        send_bits(16'h00, 8);
        chk("nb0_count", 32'(bit_count), 8);
        chk("nb0_pready", 32'(parity_ready), 1);

        // asynchronous reset in PARITY
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_pout", 32'(parity_out), 0);
        chk("arst_pready", 32'(parity_ready), 0);
        chk("arst_count", 32'(bit_count), 0);
        chk("arst_perr", 32'(parity_err), 0);
`ifdef PARITY_ERR_COUNT_EN
        model_cnt = 0;
        chk("arst_errcnt", 32'(err_count), 0);
`endif
        #2 reset = 1'b0;

        // nbits=0 after reset runs MAX_BITS data bits
        start_frame(3'd1, '0);
        send_bits(16'hFF, 7);
        chk("post_pready7", 32'(parity_ready), 0);
        send_bits(16'h1, 1);
        chk("post_pready8", 32'(parity_ready), 1);
        chk("post_count", 32'(bit_count), 8);
        chk("post_pout", 32'(parity_out), 0);
        send_parity(1'b0, 1'b0);

        tick(); tick();
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_serial_unit.md
# parity_serial_unit

Parametrised serial parity generator/checker for UART-style framing. It accumulates parity over a configurable number of serially presented data bits, supports none/even/odd/mark/space modes, then consumes one parity slot. In that slot it compares the received bit against the expected one and reports a frame-level error. One instance serves a UART TX path (expected parity drives the line) or an RX path (the received parity bit is checked).

## Interface
- `MAX_BITS`, default 8: maximum data bits per frame, legal 1..16.
- `NB_W`, default `$clog2(MAX_BITS+1)`: width of bit-count fields.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin frame; latches `mode`/`nbits`, clears accumulator.
- `abort` in 1: drop current frame, return to IDLE.
- `mode` in 3: 0 none, 1 even, 2 odd, 3 mark, 4 space; 5–7 treated as none.
- `nbits` in NB_W: data bits per frame; 0 or >MAX_BITS treated as MAX_BITS.
- `din` in 1: serial data/parity bit.
- `din_valid` in 1: `din` qualifier, sampled on `clk`.
- `busy` out 1: high in ACCUM or PARITY.
- `parity_out` out 1: expected parity bit for the latched mode and bits so far.
- `parity_ready` out 1: high in PARITY state (all data bits consumed).
- `bit_count` out NB_W: data bits consumed in current frame.
- `done` out 1: one-cycle pulse at frame end.
- `parity_err` out 1: mismatch result of last frame, valid from `done`, held until next `start`.

## Operation
- States: IDLE, ACCUM, PARITY.
- IDLE → ACCUM on `start`:
  - latch mode (`mode_q`) and clamped `nbits` (`nb_q`);
  - accumulator ← 1 for odd, else 0;
  - `bit_count` ← 0, `parity_err` ← 0.
- ACCUM, on each `din_valid`:
  - accumulator ^= `din`;
  - `bit_count` += 1.
- On the bit making `bit_count == nb_q`:
  - mode none: → IDLE, `done` pulses next cycle, `parity_err` = 0;
  - otherwise: → PARITY.
- PARITY, on `din_valid`:
  - `parity_err` ← (`din` != `parity_out`);
  - → IDLE, `done` pulses.
  - A TX user ties `din` to `parity_out`.
- `parity_out` by mode:
  - even/odd: accumulator;
  - mark: 1;
  - space: 0;
  - none: 0.
- Priority in any state: `abort` > `start` > `din_valid`.
  - `abort`: → IDLE, no `done`, `parity_err` unchanged.
  - `start` while busy restarts the frame; a coincident `din_valid` is discarded.
- `mode`/`nbits` changes outside a `start` cycle have no effect on the current frame.
- `din_valid` in IDLE is ignored.

## Timing
- All state is registered; outputs come directly from flops.
- Reset values: `busy` 0, `parity_out` 0, `parity_ready` 0, `bit_count` 0, `done` 0, `parity_err` 0; state IDLE.
- Reset mid-frame aborts immediately and asynchronously; no `done`.
- `start` sampled at edge N: `busy` high, `bit_count` 0 after edge N.
- Each `din_valid` edge updates `bit_count`/`parity_out` visibly after that edge; one bit per cycle max, back-to-back allowed.
- Last data bit at edge M:
  - parity modes: `parity_ready` high after M;
  - none: `done` high for the cycle after M, `busy` low.
- Parity slot at edge P: `done` and final `parity_err` valid after P; `done` low after P+1.
- `start` may be asserted in the same cycle `done` is high; the new frame begins and `parity_err` clears after that edge.

## Configuration
- `PARITY_ERR_COUNT_EN`
- Defined:
  - adds output `err_count` [15:0], a saturating count of frames with `parity_err` = 1;
  - increments on the edge producing an erroneous `done`, holds at 16'hFFFF;
  - cleared only by `reset`;
  - `abort` does not affect it.
- Undefined: the port and counter do not exist; all other behaviour is identical.

## Test plan
- Even, nbits=8, bits of 0x5A LSB-first, then din=0 in slot → `parity_out`=0 at `parity_ready`, `done` pulse, `parity_err`=0.
- Odd, nbits=8, 0x5A, then din=0 → `parity_out`=1, `parity_err`=1; with the macro, `err_count`=1.
- Mode none, nbits=7, 0x41 back-to-back → `done` the cycle after the 7th bit, no `parity_ready`, `bit_count`=7.
- Mark, nbits=5, 0x00, then din=1 → `parity_out`=1, `parity_err`=0; space with din=1 → `parity_err`=1.
- Restart: even, 3 bits in, `start`+`din_valid` same cycle → `bit_count`=0, `busy`=1. Then `abort` → IDLE, no `done`, previous `parity_err` held.
- `reset` pulsed asynchronously in PARITY state → all outputs 0 before the next edge; nbits=0 on the next frame runs 8 bits.
